// File: rtl/jk7_down_counter.sv
// jk7_down_counter: modulo-7 down counter built from JK flip-flop cells,
// with cascadable borrow out and a sticky underflow flag.
module jk7_down_counter (
   input  logic       Cp,
   input  logic       R,
   input  logic       En,
   input  logic       Ld,
   input  logic [2:0] D,
   input  logic       Clr,
   output logic       y1,
   output logic       y2,
   output logic       y3,
   output logic       Bo,
   output logic       Uf
);
   logic [2:0] q;
   logic [2:0] nxt;
   logic [2:0] j;
   logic [2:0] k;
   logic       wrap;
   // Illegal state 7 recovers to 6 whenever no load is requested.
   always_comb begin
      nxt = Ld ? ((D == 3'd7) ? 3'd6 : D)
          : (q == 3'd7) ? 3'd6
          : En ? ((q == 3'd0) ? 3'd6 : 3'(q - 3'd1))
          : q;
      j = nxt & ~q;
      k = ~nxt & q;
   end
   assign wrap = En & ~Ld & (q == 3'd0);
   assign Bo   = wrap;
   assign {y3, y2, y1} = q;
   always_ff @(posedge Cp or negedge R) begin
      if (!R) begin
         q  <= 3'd0;
         Uf <= 1'b0;
      end else begin
         for (int i = 0; i < 3; i++) q[i] <= (j[i] & ~q[i]) | (~k[i] & q[i]);
         Uf <= wrap | (Uf & ~Clr);
      end
   end
endmodule

// File: tb/tb_jk7_down_counter.sv
// tb_jk7_down_counter: directed checks of the mod-7 down counter, including
// illegal-state recovery, async reset and a two-stage mod-49 cascade.
module tb_jk7_down_counter;
   logic       Cp = 1'b0;
   logic       R = 1'b0;
   logic       En = 1'b0;
   logic       Ld = 1'b0;
   logic [2:0] D = 3'd0;
   logic       Clr = 1'b0;
   logic       y1, y2, y3, Bo, Uf;
   logic       cen = 1'b0;
   logic       l1, l2, l3, lbo, luf;
   logic       h1, h2, h3, hbo, huf;
   int         tests = 0;
   int         fails = 0;
   jk7_down_counter dut (.Cp(Cp), .R(R), .En(En), .Ld(Ld), .D(D), .Clr(Clr),
      .y1(y1), .y2(y2), .y3(y3), .Bo(Bo), .Uf(Uf));
   jk7_down_counter lo (.Cp(Cp), .R(R), .En(cen), .Ld(1'b0), .D(3'd0), .Clr(1'b0),
      .y1(l1), .y2(l2), .y3(l3), .Bo(lbo), .Uf(luf));
   jk7_down_counter hi (.Cp(Cp), .R(R), .En(lbo), .Ld(1'b0), .D(3'd0), .Clr(1'b0),
      .y1(h1), .y2(h2), .y3(h3), .Bo(hbo), .Uf(huf));
   always #5 Cp = ~Cp;
   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge Cp);
      @(negedge Cp);
   endtask
   function automatic int cnt();
      return int'({y3, y2, y1});
   endfunction
   initial begin
      int seq[8] = '{6, 5, 4, 3, 2, 1, 0, 6};
      @(negedge Cp);
      chk("rst_cnt", cnt(), 0);
      chk("rst_uf", int'(Uf), 0);
      chk("rst_bo_en0", int'(Bo), 0);
      En = 1'b1;
      #1 chk("rst_bo_en1", int'(Bo), 1);
      Ld = 1'b1; D = 3'd5;
      tick();
      chk("rst_ignores_ld", cnt(), 0);
      Ld = 1'b0;
      R = 1'b1;
      #1 chk("pre_wrap_bo", int'(Bo), 1);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("dec_cnt%0d", i), cnt(), seq[i]);
         chk($sformatf("dec_uf%0d", i), int'(Uf), 1);
         chk($sformatf("dec_bo%0d", i), int'(Bo), (seq[i] == 0) ? 1 : 0);
      end
      Ld = 1'b1; D = 3'd3;
      tick();
      chk("load_wins", cnt(), 3);
      D = 3'd7;
      tick();
      chk("load_sat", cnt(), 6);
      chk("load_sat_uf", int'(Uf), 1);
      D = 3'd0;
      tick();
      chk("load0_bo_ld1", int'(Bo), 0);
      chk("load0", cnt(), 0);
      Ld = 1'b0; Clr = 1'b1;
      #1 chk("clr_wrap_bo", int'(Bo), 1);
      tick();
      chk("clr_wrap_cnt", cnt(), 6);
      chk("clr_wrap_uf", int'(Uf), 1);
      En = 1'b0;
      tick();
      chk("clr_cnt", cnt(), 6);
      chk("clr_uf", int'(Uf), 0);
      Clr = 1'b0; Ld = 1'b1; D = 3'd6;
      tick();
      chk("load6_uf", int'(Uf), 0);
      Ld = 1'b0;
      force dut.q = 3'd7;
      #1 release dut.q;
      #1 chk("ill_cnt", cnt(), 7);
      chk("ill_bo", int'(Bo), 0);
      tick();
      chk("ill_rec_cnt", cnt(), 6);
      chk("ill_rec_uf", int'(Uf), 0);
      Ld = 1'b1; D = 3'd0;
      tick();
      Ld = 1'b0; En = 1'b1;
      tick();
      chk("set_uf", int'(Uf), 1);
      Ld = 1'b1; D = 3'd4;
      tick();
      chk("at4", cnt(), 4);
      Ld = 1'b0;
      #1 R = 1'b0;
      #1 chk("async_cnt", cnt(), 0);
      chk("async_uf", int'(Uf), 0);
      #1 R = 1'b1;
      tick();
      chk("post_rst_cnt", cnt(), 6);
      chk("post_rst_uf", int'(Uf), 1);
      En = 1'b0;
      R = 1'b0;
      #1 R = 1'b1;
      cen = 1'b1;
      for (int e = 1; e <= 49; e++) begin
         tick();
         chk($sformatf("chain_lo%0d", e), int'({l3, l2, l1}), ((49 - e) % 49) % 7);
         chk($sformatf("chain_hi%0d", e), int'({h3, h2, h1}), ((49 - e) % 49) / 7);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
